// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a + ~b + 1, LSB first) with a start/done handshake.
// Optional macro SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-1:0]   part;
    logic [WIDTH-1:0]   part_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               fa_s;
    logic               fa_c;
    logic               cnt_last;
    logic               accept;
`ifdef SUB_OVF_EN
    logic               a_msb;
    logic               b_msb;
`endif

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // One full-adder slice; the sum bit enters the partial register from the top
    assign fa_s     = sh_a[0] ^ sh_b[0] ^ carry;
    assign fa_c     = maj3(sh_a[0], sh_b[0], carry);
    assign part_nxt = {fa_s, part[WIDTH-1:1]};
    assign cnt_last = (cnt == CNT_W'(WIDTH - 1));
    assign accept   = start && (state != S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands shift right while the partial result fills from the MSB side;
    // visible results only update on the final slice so diff never shows a partial value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            part   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            sh_a   <= a;
            sh_b   <= ~b;
            carry  <= 1'b1;
            cnt    <= '0;
`ifdef SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
        end else if (state == S_RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            part  <= part_nxt;
            carry <= fa_c;
            cnt   <= cnt + CNT_W'(1);
            if (cnt_last) begin
                diff   <= part_nxt;
                borrow <= ~fa_c;
                zero   <= ~|part_nxt;
`ifdef SUB_OVF_EN
                ovf    <= (a_msb != b_msb) && (fa_s != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=6), including handshake corner cases.
module tb_serial_subtractor;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;

    int n_cmp;
    int n_fail;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
`ifdef SUB_OVF_EN
        .zero   (zero),
        .ovf    (ovf)
`else
        .zero   (zero)
`endif
    );

`ifndef SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one start pulse and wait (bounded) for done; returns edges until done.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, output int lat);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        do_op(v.a, v.b, lat);
        check({name, " latency"}, lat, 7);
        check({name, " diff"},    diff, v.diff);
        check({name, " borrow"},  borrow, v.borrow);
        check({name, " zero"},    zero, v.zero);
        check({name, " busy@done"}, busy, 0);
        @(negedge clk);
        check({name, " done pulse"}, done, 0);
    endtask

    initial begin
        int n_busy;
        int n_done;
        int lat;
        n_cmp  = 0;
        n_fail = 0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        rst_n  = 1'b0;

        vecs[0] = '{6'd45, 6'd18, 6'd27, 1'b0, 1'b0};
        vecs[1] = '{6'd18, 6'd45, 6'd37, 1'b1, 1'b0};
        vecs[2] = '{6'd0,  6'd0,  6'd0,  1'b0, 1'b1};
        vecs[3] = '{6'd63, 6'd63, 6'd0,  1'b0, 1'b1};
        vecs[4] = '{6'd0,  6'd1,  6'd63, 1'b1, 1'b0};
        vecs[5] = '{6'd10, 6'd3,  6'd7,  1'b0, 1'b0};
        vecs[6] = '{6'd1,  6'd0,  6'd1,  1'b0, 1'b0};
        vecs[7] = '{6'd32, 6'd33, 6'd63, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("reset busy",   busy, 0);
        check("reset done",   done, 0);
        check("reset diff",   diff, 0);
        check("reset borrow", borrow, 0);
        check("reset zero",   zero, 0);
        check("reset ovf",    ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Second start while busy must be ignored; diff holds the old result during RUN
        n_busy = 0;
        n_done = 0;
        a      = 6'd45;
        b      = 6'd18;
        start  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                check("ignore diff", diff, 27);
            end
            if (i == 2) check("diff hold in run", diff, 63);
            start = (i == 1);
            if (i == 1) begin
                a = 6'd1;
                b = 6'd1;
            end
        end
        check("ignore busy cycles", n_busy, 6);
        check("ignore done count",  n_done, 1);

        // Reset in the middle of an operation
        a     = 6'd45;
        b     = 6'd18;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy",   busy, 0);
        check("abort done",   done, 0);
        check("abort diff",   diff, 0);
        check("abort borrow", borrow, 0);
        check("abort zero",   zero, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort no done", n_done, 0);
        run_vec("after abort", '{6'd10, 6'd3, 6'd7, 1'b0, 1'b0});

        // Start held through DONE: back-to-back operation
        do_op(6'd45, 6'd18, lat);
        start = 1'b1;
        check("b2b first lat",  lat, 7);
        check("b2b first diff", diff, 27);
        a = 6'd10;
        b = 6'd3;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b second lat",  lat, 7);
        check("b2b second diff", diff, 7);
        @(negedge clk);

`ifdef SUB_OVF_EN
        do_op(6'd31, 6'd32, lat);
        check("ovf lat",    lat, 7);
        check("ovf diff",   diff, 63);
        check("ovf borrow", borrow, 1);
        check("ovf set",    ovf, 1);
        @(negedge clk);
        do_op(6'd5, 6'd3, lat);
        check("noovf diff", diff, 2);
        check("noovf clr",  ovf, 0);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
